// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin sync, clock deglitch, 11-bit deserialiser, timeout.
// Optional PS2_RX_ERRCNT_EN adds a saturating err_count output.
module ps2_rx_frame #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       valid,
    output logic       error,
    output logic [7:0] data,
`ifdef PS2_RX_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       busy_rx
);

    localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   sample;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign sample = data_sync_q[SYNC_STAGES-1];

    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             filt_q, filt_d;
    logic             filt_dly_q;
    logic             fall;

    // Counter restarts whenever the synced level agrees with the filtered one.
    always_comb begin
        filt_cnt_d = '0;
        filt_d     = filt_q;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
        end
    end

    assign fall = filt_dly_q & ~filt_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_ok_q, parity_ok_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic [7:0]        data_q, data_d;
    logic              timeout;

    assign timeout = (state_q != StIdle) && !fall &&
                     (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        timer_d     = timer_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        data_d      = data_q;

        if (state_q != StIdle) begin
            timer_d = fall ? '0 : timer_q + TimerW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (fall && !sample) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {sample, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    parity_ok_d = ^{shift_q, sample};
                    state_d     = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (sample && parity_ok_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A fall in the same cycle already excluded the timeout above.
        if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
        end

        if (state_d == StIdle) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            timer_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            timer_q     <= timer_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            data_q      <= data_d;
        end
    end

    assign valid   = valid_q;
    assign error   = error_q;
    assign data    = data_q;
    assign busy_rx = (state_q != StIdle);

`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (error_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frames are driven on the raw pins, expected outcomes
// are queued at drive time and popped when valid/error pulses.
module tb_ps2_rx_frame;

    localparam int unsigned SyncStages    = 2;
    localparam int unsigned FilterLen     = 8;
    localparam int unsigned TimeoutCycles = 5000;
    localparam int          FrameLat      = SyncStages + FilterLen + 1;
    localparam int          HalfSlow      = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       valid;
    logic       error;
    logic [7:0] data;
    logic       busy_rx;
`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    ps2_rx_frame #(
        .SYNC_STAGES   (SyncStages),
        .FILTER_LEN    (FilterLen),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .valid    (valid),
        .error    (error),
        .data     (data),
`ifdef PS2_RX_ERRCNT_EN
        .err_count(err_count),
`endif
        .busy_rx  (busy_rx)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1 || error === 1'b1) begin
            check_eq("excl", {31'd0, valid & error}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected", exp_q.size(), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("kind", {31'd0, error}, {31'd0, mon_e.is_err});
                check_eq("data", {24'd0, data}, {24'd0, mon_e.data});
                if (mon_e.lat >= 0) begin
                    check_eq("latency", cyc - last_fall_cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par,
                                             input bit bad_stop);
        logic par;
        par = ~^d;
        if (bad_par) par = ~par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Drives the first nbits of a frame; data changes mid-high, optional 5-cycle clk glitch.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half,
                             input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            if (glitch) begin
                wait_cyc(15);
                ps2_clk = 1'b0;
                wait_cyc(5);
                ps2_clk = 1'b1;
                wait_cyc(half / 2 - 20);
            end else begin
                wait_cyc(half / 2);
            end
            ps2_data = bits[i];
            wait_cyc(half - half / 2);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(half);
            ps2_clk = 1'b1;
        end
        wait_cyc(half / 2);
        ps2_data = 1'b1;
        wait_cyc(half - half / 2);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            wait_cyc(1);
            n++;
        end
        check_eq("drain", exp_q.size(), 32'd0);
        exp_q.delete();
        check_eq("busy_idle", {31'd0, busy_rx}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit glitch, input int half);
        exp_t e;
        if (bad_par || bad_stop) begin
            e = '{is_err: 1'b1, data: model_data, lat: FrameLat};
        end else begin
            model_data = d;
            e = '{is_err: 1'b0, data: d, lat: FrameLat};
        end
        exp_q.push_back(e);
        send_bits(mk_frame(d, bad_par, bad_stop), 11, half, glitch);
        wait_drain(100);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        check_eq("rst_data", {24'd0, data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_rx}, 32'd0);
        reset = 1'b1;
        wait_cyc(20);

        run_frame(8'hEE, 1'b0, 1'b0, 1'b0, HalfSlow);
        // E0 has odd weight already, so the parity bit is inverted to make it bad.
        run_frame(8'hE0, 1'b1, 1'b0, 1'b0, HalfSlow);
        run_frame(8'h4E, 1'b0, 1'b1, 1'b0, HalfSlow);
        run_frame(8'hE7, 1'b0, 1'b0, 1'b0, HalfSlow);

        // Stall after the 4th data bit; error lands TIMEOUT_CYCLES after the fall is consumed.
        e = '{is_err: 1'b1, data: model_data, lat: FrameLat + TimeoutCycles};
        exp_q.push_back(e);
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5, HalfSlow, 1'b0);
        check_eq("busy_stall", {31'd0, busy_rx}, 32'd1);
        wait_drain(TimeoutCycles + 200);
        wait_cyc(1000);
        run_frame(8'hEE, 1'b0, 1'b0, 1'b0, HalfSlow);

        for (int i = 0; i < 3; i++) begin
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
        end
        wait_cyc(30);
        check_eq("glitch_idle_busy", {31'd0, busy_rx}, 32'd0);
        model_data = 8'h00;
        run_frame(8'hEE, 1'b0, 1'b0, 1'b1, HalfSlow);

`ifdef PS2_RX_ERRCNT_EN
        check_eq("errcnt_3", {24'd0, err_count}, 32'd3);
`endif

        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 6, HalfSlow, 1'b0);
        check_eq("busy_mid", {31'd0, busy_rx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_data", {24'd0, data}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy_rx}, 32'd0);
        reset = 1'b1;
        model_data = 8'h00;
        wait_cyc(20);
`ifdef PS2_RX_ERRCNT_EN
        check_eq("errcnt_rst", {24'd0, err_count}, 32'd0);
`endif
        run_frame(8'h4E, 1'b0, 1'b0, 1'b0, HalfSlow);

`ifdef PS2_RX_ERRCNT_EN
        for (int i = 0; i < 260; i++) begin
            run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 10);
        end
        check_eq("errcnt_sat", {24'd0, err_count}, 32'hFF);
`endif

        wait_cyc(20);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
